alu_mc: RTL and testbench
=========================

# alu_mc

Parametrised multi-cycle ALU for the pipeline execute stage, the next generation of the fixed 64-bit combinational ALU. It adds width parametrisation, signed compare, arithmetic shift and an iterative shift-add multiplier. It registers the result and ZERO flag behind a valid/ready handshake on both sides, so the execute stage can stall on long operations. Single-cycle ops sustain one result per cycle; MUL occupies the unit for WIDTH cycles.

## Interface
- WIDTH, 64, operand/result width; power of two, ≥ 8
- SHW, $clog2(WIDTH), shift-amount width (derived, do not override)

- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  operation presented
- in_ready  output  1  unit accepts operation this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- ALUOp  input  4  operation code
- out_valid  output  1  Result/ZERO valid
- out_ready  input  1  consumer takes result this cycle
- Result  output  WIDTH  registered result
- ZERO  output  1  registered; 1 when Result == 0

## Operation
- Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 XOR, 0101 SLL, 0110 SRL, 0111 MUL, 1000 SRA, 1001 SLT.
- Undefined opcodes (1010–1111) give Result = 0 and ZERO = 1 as a single-cycle op.
- Shifts use b[SHW-1:0] only. ADD, SUB and MUL wrap modulo 2^WIDTH.
- MUL returns the low WIDTH bits of the product, which is sign-agnostic.
- SLT returns 1 when $signed(a) < $signed(b), else 0.
- Accept = in_valid && in_ready. a, b and ALUOp are sampled only on accept.
- FSM states:
  - IDLE: in_ready = 1, out_valid = 0.
    - Accept of a single-cycle op → HOLD, with the result registered.
    - Accept of MUL → BUSY.
  - BUSY: in_ready = 0, out_valid = 0.
    - On entry: mcand = a, mplier = b, acc = 0, cnt = 0.
    - Each cycle: if mplier[0], acc += mcand; then mcand <<= 1, mplier >>= 1, cnt++.
    - In the cycle with cnt == WIDTH-1: load Result from the updated acc → HOLD.
  - HOLD: out_valid = 1, Result/ZERO stable.
    - in_ready = out_ready.
    - out_ready && in_valid: accept the new op (back-to-back). Next state is HOLD (single-cycle op) or BUSY (MUL).
    - out_ready && !in_valid → IDLE.
    - !out_ready → stay in HOLD and ignore inputs.
- ZERO is computed from the value loaded into Result and changes only with it.

## Timing
- Reset values: state IDLE, Result = 0, ZERO = 0, out_valid = 0, in_ready = 1 (the cycle after reset deasserts). Internal acc, mcand, mplier and cnt clear to 0.
- Single-cycle op: accepted at edge N, out_valid high from edge N+1.
- MUL: accepted at edge N, BUSY for WIDTH cycles, out_valid high from edge N+WIDTH+1.
- Back-to-back single-cycle ops with out_ready held high give one result per clock.
- Reset asserted mid-MUL or in HOLD abandons the operation. No result is produced and the state is IDLE on the next edge.
- in_valid while in BUSY is ignored (in_ready = 0). The producer must hold its inputs.
- Reset has priority over every handshake event in the same cycle.

## Configuration
- ALU_MC_MUL_EN defined:
  - MUL executes iteratively as described.
  - The BUSY state, acc, mcand, mplier and cnt are present.
- ALU_MC_MUL_EN undefined:
  - Opcode 0111 is treated as undefined: single-cycle, Result = 0, ZERO = 1.
  - No BUSY state or multiplier registers are present.
  - in_ready depends only on the IDLE/HOLD rules.

## Test plan
- Reset, then ADD a=64'hFFFF_FFFF_FFFF_FFFF, b=1, out_ready=1 → out_valid one cycle after accept, Result = 0, ZERO = 1.
- SLT a=64'hFFFF_FFFF_FFFF_FFFE (-2), b=3 → Result = 1. SRA of the same a with b=64'h41 (shift 1) → Result = 64'hFFFF_FFFF_FFFF_FFFF. SRL of the same a with b=1 → Result = 64'h7FFF_FFFF_FFFF_FFFF.
- MUL a=12345, b=6789 (ALU_MC_MUL_EN defined):
  - in_ready = 0 for 64 cycles.
  - out_valid at accept+65 with Result = 83810205.
  - MUL a=2^63, b=2 → Result = 0, ZERO = 1.
- Backpressure: hold out_ready = 0 for 5 cycles after SUB 10−3 → Result stays 7 and in_ready stays 0. out_ready = 1 with in_valid = 1 (OR 5|2) → next cycle Result = 7.
- Throughput: 8 consecutive XOR ops with in_valid = out_ready = 1 → 8 results on 8 consecutive cycles, in order.
- Assert reset 10 cycles into a MUL → no out_valid pulse, IDLE afterwards, and the next ADD 1+1 returns 2. Rebuild without ALU_MC_MUL_EN → opcode 0111 returns 0, ZERO = 1, after 1 cycle.

Source files
------------

// File: rtl/alu_mc_if.sv
// Operation/result handshake bundle for alu_mc: valid/ready on the operand side and on the result side.
interface alu_mc_if #(
    parameter int unsigned WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       ALUOp;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Result;
    logic             ZERO;

    modport master (
        output in_valid, a, b, ALUOp, out_ready,
        input  in_ready, out_valid, Result, ZERO
    );

    modport slave (
        input  in_valid, a, b, ALUOp, out_ready,
        output in_ready, out_valid, Result, ZERO
    );
endinterface

// File: rtl/alu_mc.sv
// Parametrised multi-cycle ALU with registered Result/ZERO behind valid/ready handshakes.
// Define ALU_MC_MUL_EN to build the iterative shift-add multiplier (opcode 0111); otherwise MUL is undefined.
module alu_mc #(
    parameter int unsigned WIDTH = 64
) (
    input  logic     clk,
    input  logic     reset,
    alu_mc_if.slave  bus
);
    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b1000;
    localparam logic [3:0] OP_SLT = 4'b1001;

`ifdef ALU_MC_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b0111;
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_HOLD} state_e;
`else
    typedef enum logic [0:0] {ST_IDLE, ST_HOLD} state_e;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             out_valid_q, out_valid_d;

`ifdef ALU_MC_MUL_EN
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
`endif

    logic [WIDTH-1:0] alu_res_c;
    logic [SHW-1:0]   shamt_c;
    logic             in_ready_c;
    logic             accept_c;

    // HOLD only frees the unit when the consumer takes the current result
    assign in_ready_c = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && bus.out_ready);
    assign accept_c   = bus.in_valid && in_ready_c;
    assign shamt_c    = bus.b[SHW-1:0];

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.Result    = result_q;
    assign bus.ZERO      = zero_q;

    // Single-cycle datapath; MUL and undefined opcodes fall to zero here
    always_comb begin
        alu_res_c = '0;
        case (bus.ALUOp)
            OP_AND:  alu_res_c = bus.a & bus.b;
            OP_OR:   alu_res_c = bus.a | bus.b;
            OP_ADD:  alu_res_c = bus.a + bus.b;
            OP_SUB:  alu_res_c = bus.a - bus.b;
            OP_XOR:  alu_res_c = bus.a ^ bus.b;
            OP_SLL:  alu_res_c = bus.a << shamt_c;
            OP_SRL:  alu_res_c = bus.a >> shamt_c;
            OP_SRA:  alu_res_c = WIDTH'($signed(bus.a) >>> shamt_c);
            OP_SLT:  alu_res_c = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            default: alu_res_c = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
`ifdef ALU_MC_MUL_EN
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
`endif
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (accept_c) begin
                    state_d     = ST_HOLD;
                    result_d    = alu_res_c;
                    zero_d      = (alu_res_c == '0);
                    out_valid_d = 1'b1;
`ifdef ALU_MC_MUL_EN
                    // MUL keeps the previous Result/ZERO until the product lands
                    if (bus.ALUOp == OP_MUL) begin
                        state_d     = ST_BUSY;
                        result_d    = result_q;
                        zero_d      = zero_q;
                        out_valid_d = 1'b0;
                        acc_d       = '0;
                        mcand_d     = bus.a;
                        mplier_d    = bus.b;
                        cnt_d       = '0;
                    end
`endif
                end else if ((state_q == ST_HOLD) && bus.out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
`ifdef ALU_MC_MUL_EN
            ST_BUSY: begin
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SHW'(1);
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    state_d     = ST_HOLD;
                    result_d    = acc_d;
                    zero_d      = (acc_d == '0);
                    out_valid_d = 1'b1;
                end
            end
`endif
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef ALU_MC_MUL_EN
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
`ifdef ALU_MC_MUL_EN
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=64): directed vectors plus a queue-based reference model.
module tb_alu_mc;
    localparam int unsigned W = 64;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    alu_mc_if #(.WIDTH(W)) bus ();

    alu_mc #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: what each accepted operation must produce
    function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        int sh;
        sh = int'(b[5:0]);
        case (op)
            4'd0: return a & b;
            4'd1: return a | b;
            4'd2: return a + b;
            4'd3: return a - b;
            4'd4: return a ^ b;
            4'd5: return a << sh;
            4'd6: return a >> sh;
`ifdef ALU_MC_MUL_EN
            4'd7: return a * b;
`endif
            4'd8: return $signed(a) >>> sh;
            4'd9: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            default: return 64'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    logic [63:0] exp_q[$];
    logic [63:0] exp_v;

    // Scoreboard: pop on every consumed result, push on every accepted operation
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_result: got %h required no result", bus.Result);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("sb_result", bus.Result, exp_v);
                    check("sb_zero", 64'(bus.ZERO), 64'(exp_v == 64'd0));
                end
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.ALUOp, bus.a, bus.b));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an op and hold it until accepted; returns 1 time unit after the accept edge
    task automatic op1(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        int n;
        bus.ALUOp    = op;
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 for %0d cycles required accept", n);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    logic [63:0] xa[8];
    logic [63:0] xb;

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish required finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int busy_bad;
        int ov_cnt;
        n_tests = 0;
        n_fail  = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.ALUOp     = 4'd0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        step();

        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result", bus.Result, 64'd0);
        check("rst_zero", 64'(bus.ZERO), 64'd0);

        // ADD wrap to zero
        step();
        op1(4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        @(negedge clk);
        check("add_valid", 64'(bus.out_valid), 64'd1);
        check("add_result", bus.Result, 64'd0);
        check("add_zero", 64'(bus.ZERO), 64'd1);

        step();
        op1(4'd9, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3);
        @(negedge clk);
        check("slt_result", bus.Result, 64'd1);
        check("slt_zero", 64'(bus.ZERO), 64'd0);

        step();
        op1(4'd8, 64'hFFFF_FFFF_FFFF_FFFE, 64'h41);
        @(negedge clk);
        check("sra_result", bus.Result, 64'hFFFF_FFFF_FFFF_FFFF);

        step();
        op1(4'd6, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1);
        @(negedge clk);
        check("srl_result", bus.Result, 64'h7FFF_FFFF_FFFF_FFFF);

        step();
        op1(4'd5, 64'h8000_0000_0000_0001, 64'h7F);
        @(negedge clk);
        check("sll_result", bus.Result, 64'h8000_0000_0000_0000);

`ifdef ALU_MC_MUL_EN
        step();
        op1(4'd7, 64'd12345, 64'd6789);
        cnt = 0;
        busy_bad = 0;
        @(negedge clk);
        while (!bus.out_valid && cnt < 200) begin
            if (bus.in_ready) busy_bad++;
            cnt++;
            @(negedge clk);
        end
        check("mul_busy_cycles", 64'(cnt), 64'd64);
        check("mul_busy_in_ready", 64'(busy_bad), 64'd0);
        check("mul_result", bus.Result, 64'd83810205);

        step();
        op1(4'd7, 64'h8000_0000_0000_0000, 64'd2);
        cnt = 0;
        @(negedge clk);
        while (!bus.out_valid && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        check("mul_ovf_result", bus.Result, 64'd0);
        check("mul_ovf_zero", 64'(bus.ZERO), 64'd1);
`else
        step();
        op1(4'd7, 64'd12345, 64'd6789);
        @(negedge clk);
        check("mul_undef_valid", 64'(bus.out_valid), 64'd1);
        check("mul_undef_result", bus.Result, 64'd0);
        check("mul_undef_zero", 64'(bus.ZERO), 64'd1);
`endif

        step();
        op1(4'd12, 64'd5, 64'd9);
        @(negedge clk);
        check("undef_result", bus.Result, 64'd0);
        check("undef_zero", 64'(bus.ZERO), 64'd1);

        // Backpressure: SUB held while a new op waits
        step();
        bus.out_ready = 1'b0;
        op1(4'd3, 64'd10, 64'd3);
        bus.ALUOp    = 4'd1;
        bus.a        = 64'd5;
        bus.b        = 64'd2;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 64'(bus.out_valid), 64'd1);
            check("bp_result", bus.Result, 64'd7);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        end
        step();
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("bp_or_valid", 64'(bus.out_valid), 64'd1);
        check("bp_or_result", bus.Result, 64'd7);

        // Throughput: 8 XORs back-to-back
        step();
        xb = 64'h0F0F_0000_FFFF_1234;
        for (int i = 0; i < 8; i++) xa[i] = 64'h1111_1111_1111_1111 * 64'(i + 1);
        for (int i = 0; i < 8; i++) begin
            bus.ALUOp    = 4'd4;
            bus.a        = xa[i];
            bus.b        = xb;
            bus.in_valid = 1'b1;
            @(negedge clk);
            if (i > 0) begin
                check("tp_valid", 64'(bus.out_valid), 64'd1);
                check("tp_result", bus.Result, xa[i-1] ^ xb);
            end
            step();
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("tp_last_result", bus.Result, xa[7] ^ xb);
        @(negedge clk);
        check("tp_idle", 64'(bus.out_valid), 64'd0);

        // Reset while holding a result
        step();
        bus.out_ready = 1'b0;
        op1(4'd2, 64'd3, 64'd4);
        @(negedge clk);
        check("hold_rst_pre_valid", 64'(bus.out_valid), 64'd1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("hold_rst_valid", 64'(bus.out_valid), 64'd0);
        check("hold_rst_in_ready", 64'(bus.in_ready), 64'd1);

`ifdef ALU_MC_MUL_EN
        // Reset mid-MUL abandons the product
        step();
        op1(4'd7, 64'd5, 64'd7);
        repeat (9) @(negedge clk);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        ov_cnt = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (bus.out_valid) ov_cnt++;
        end
        check("mulrst_no_valid", 64'(ov_cnt), 64'd0);
        check("mulrst_in_ready", 64'(bus.in_ready), 64'd1);
`else
        ov_cnt = 0;
`endif
        step();
        op1(4'd2, 64'd1, 64'd1);
        @(negedge clk);
        check("post_rst_add", bus.Result, 64'd2);
        check("post_rst_zero", 64'(bus.ZERO), 64'd0);

        repeat (3) step();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
